// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 11-bit frame (start, data MSB first, parity, stop).
//
// Ports:
//   clk_3125    - system clock, all logic on the rising edge
//   rst_n       - synchronous active-low reset
//   rx          - serial line, idle high, asynchronous to clk_3125
//   parity_type - 0 = even, 1 = odd; used when the parity bit is sampled
//   rx_msg      - last received data byte
//   rx_parity   - last received parity bit as it appeared on the line
//   rx_complete - one-cycle pulse when a frame finishes (good or bad)
//   parity_err  - last frame's parity mismatch flag
//   frame_err   - last frame's stop bit was sampled low
//
// Each bit occupies CLKS_PER_BIT clocks and is sampled once, mid-bit. The result
// outputs change only at the end of the stop bit and hold until the next frame.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 14
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity,
  output logic       rx_complete,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] MidCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            par_bit_q;
  logic            par_err_q;
  logic            stop_bit_q;
  logic [7:0]      rx_msg_q;
  logic            rx_parity_q;
  logic            rx_complete_q;
  logic            parity_err_q;
  logic            frame_err_q;

  logic mid_bit;
  logic last_clk;

  assign mid_bit  = (cnt_q == MidCnt);
  assign last_clk = (cnt_q == LastCnt);

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
      stop_bit_q    <= 1'b1;
      rx_msg_q      <= 8'h00;
      rx_parity_q   <= 1'b0;
      rx_complete_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      // Two-flop synchronizer; the FSM only ever looks at rx_sync_q.
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_complete_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_sync_q) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          if (mid_bit && rx_sync_q) begin
            // Glitch, not a start bit: drop back without touching outputs.
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (last_clk) begin
            state_q <= StData;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StData: begin
          if (mid_bit) begin
            // MSB arrives first, so shift towards the top.
            shift_q <= {shift_q[6:0], rx_sync_q};
          end
          if (last_clk) begin
            cnt_q <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
              state_q <= StParity;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (mid_bit) begin
            par_bit_q <= rx_sync_q;
            // Even: expected = ^data; odd: inverted. Error when line differs.
            par_err_q <= rx_sync_q ^ (^shift_q) ^ parity_type;
          end
          if (last_clk) begin
            state_q <= StStop;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (mid_bit) begin
            stop_bit_q <= rx_sync_q;
          end
          if (last_clk) begin
            rx_msg_q      <= shift_q;
            rx_parity_q   <= par_bit_q;
            parity_err_q  <= par_err_q;
            frame_err_q   <= ~stop_bit_q;
            rx_complete_q <= 1'b1;
            state_q       <= StIdle;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_msg      = rx_msg_q;
  assign rx_parity   = rx_parity_q;
  assign rx_complete = rx_complete_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, expected results queued at send time and
// checked by an independent monitor whenever rx_complete is seen.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int Cpb = 14;
  localparam int Lat = 157;  // cycles from driving the start bit to the negedge seeing rx_complete

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk_3125   (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .parity_type(parity_type),
    .rx_msg     (rx_msg),
    .rx_parity  (rx_parity),
    .rx_complete(rx_complete),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [7:0] msg;
    logic       par;
    logic       perr;
    logic       ferr;
    bit         chk_lat;
    int         exp_cyc;
  } exp_t;

  exp_t sb[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic rst_seen = 1'b0;
  logic prev_complete = 1'b0;
  logic [7:0] hold_msg  = 8'h00;
  logic       hold_par  = 1'b0;
  logic       hold_perr = 1'b0;
  logic       hold_ferr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, one-cycle pulse, scoreboard pop, hold between frames.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      check("reset_complete", {31'd0, rx_complete}, 32'd0);
      check("reset_msg", {24'd0, rx_msg}, 32'd0);
      check("reset_flags", {29'd0, rx_parity, parity_err, frame_err}, 32'd0);
      hold_msg  = 8'h00;
      hold_par  = 1'b0;
      hold_perr = 1'b0;
      hold_ferr = 1'b0;
    end else if (rx_complete === 1'b1) begin
      check("pulse_width", {31'd0, prev_complete}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_complete: got rx_msg %0h expected no pulse (cycle %0d)",
                 rx_msg, cyc);
      end else begin
        e = sb.pop_front();
        check("rx_msg", {24'd0, rx_msg}, {24'd0, e.msg});
        check("rx_parity", {31'd0, rx_parity}, {31'd0, e.par});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        if (e.chk_lat) check("latency", cyc, e.exp_cyc);
        hold_msg  = e.msg;
        hold_par  = e.par;
        hold_perr = e.perr;
        hold_ferr = e.ferr;
      end
    end else begin
      check("hold_complete", {31'd0, rx_complete}, 32'd0);
      check("hold_outputs", {20'd0, rx_msg, rx_parity, parity_err, frame_err},
            {20'd0, hold_msg, hold_par, hold_perr, hold_ferr});
    end
    prev_complete = rx_complete;
  end

  // Called at #1 after a posedge; bits go out start, data[7]..data[0], parity, stop.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic ptype, input logic eperr, input bit expect_out,
                            input bit chk_lat);
    exp_t        e;
    logic [10:0] bits;
    parity_type = ptype;
    bits = {1'b0, data, par, stop};
    if (expect_out) begin
      e.msg     = data;
      e.par     = par;
      e.perr    = eperr;
      e.ferr    = ~stop;
      e.chk_lat = chk_lat;
      e.exp_cyc = cyc + Lat;
      sb.push_back(e);
    end
    for (int i = 10; i >= 0; i--) begin
      rx = bits[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ten back-to-back odd-parity frames; index 4 (0xFF) is cut by a reset pulse.
  logic [7:0] b2b_data [10] = '{8'h11, 8'h22, 8'h01, 8'h44, 8'hFF,
                                8'h5A, 8'h07, 8'h96, 8'h80, 8'hC3};
  logic       b2b_par  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n       = 1'b0;
    rx          = 1'b1;
    parity_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);

    // Even parity, correct parity bit.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(30);
    // Odd parity, correct parity bit.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(30);
    // Even parity, wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(30);
    // Stop bit low, then the next start follows immediately on the still-low line.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(30);

    // Short glitch: must not produce a frame; then FSM must be idle for a timed frame.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    send_frame(8'hE7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(30);

    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        fork
          send_frame(b2b_data[k], b2b_par[k], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
          begin
            repeat (45) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
          end
        join
      end else begin
        send_frame(b2b_data[k], b2b_par[k], 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
    end

    idle(200);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
